poly1305_block_sequencer: RTL and testbench
===========================================

// Module: poly1305_block_sequencer
// PURPOSE
//  Front-end sequencer for chacha_poly1305_adapter. Takes AAD and payload byte streams, zero-pads partial
//  16-byte blocks, counts byte lengths, builds the RFC 8439 length block and feeds it last.
//  Keeps exactly one block in flight. The next block is not issued until the adapter's done flag for the
//  current block rises. Sits between the DMA/stream front end and the adapter's aad/pld/len ports.
// PARAMETERS
//  TIMEOUT_CYCLES  1024  Watchdog limit in X_WAIT states. Used only with POLY_SEQ_TIMEOUT_EN.
//  LEN_W           64    Width of each byte counter and of each half of the length block.
// PORTS
//  clk         in   1    Clock.
//  rst_n       in   1    Reset: asynchronous, active-low.
//  start       in   1    Starts a message. Sampled only in IDLE.
//  aad_none    in   1    Sampled with start. 1 = skip the AAD phase; aad_bytes stays 0.
//  pld_none    in   1    Sampled with start. 1 = skip the payload phase; pld_bytes stays 0.
//  s_aad_valid / s_aad_ready  in/out 1/1  Upstream AAD handshake.
//  s_aad_data, s_aad_keep, s_aad_last  in 128/16/1  AAD beat. keep[i] = byte i valid, contiguous from bit 0.
//  s_pld_valid / s_pld_ready  in/out 1/1  Upstream payload handshake.
//  s_pld_data, s_pld_keep, s_pld_last  in 128/16/1  Payload beat. Same keep rules as AAD.
//  aad_valid, aad_data, aad_keep  out 1/128/16  To adapter. aad_ready in 1 from adapter.
//  pld_valid, pld_data, pld_keep  out 1/128/16  To adapter. pld_ready in 1 from adapter.
//  len_valid, len_block  out 1/128  To adapter. len_ready in 1 from adapter.
//  aad_done, pld_done, lens_done  in 1 each  Adapter completion flags. Treated as level; sequencer edge-detects them.
//  busy        out  1    High from start acceptance until the sequencer returns to IDLE.
//  seq_done    out  1    One-cycle pulse when the length block completes.
//  aad_bytes   out  LEN_W  Running AAD byte count.
//  pld_bytes   out  LEN_W  Running payload byte count.
//  timeout_err out  1    Sticky watchdog error. Exists only with POLY_SEQ_TIMEOUT_EN.
// BEHAVIOUR
//  Reset values: all outputs 0, state IDLE, counters 0, done edge-detect registers 0.
//  FSM states: IDLE, AAD_ISSUE, AAD_WAIT, PLD_ISSUE, PLD_WAIT, LEN_ISSUE, LEN_WAIT, FIN.
//  IDLE
//   - On start=1: clear counters, latch aad_none/pld_none, busy<=1.
//   - Next state: AAD_ISSUE, else PLD_ISSUE if aad_none, else LEN_ISSUE if both none set.
//   - start outside IDLE is ignored.
//  X_ISSUE (upstream side)
//   - s_x_ready = (state==X_ISSUE) && !x_valid. Combinational from registers.
//   - Beat accepted on s_x_valid & s_x_ready.
//   - On accept: x_data <= data with bytes where keep=0 forced to 0; x_keep <= keep; x_valid <= 1.
//   - On accept: x_bytes += popcount(keep); last flag latched.
//  X_ISSUE (adapter side)
//   - x_valid, x_data and x_keep hold stable until x_valid & x_ready at a clock edge.
//   - On that edge: x_valid <= 0 and state -> X_WAIT.
//  X_WAIT
//   - Advances on the rising edge of x_done (x_done & !x_done_q), 1-cycle detect.
//   - Latched last=0 -> X_ISSUE. Latched last=1 -> next phase (AAD->PLD or LEN; PLD->LEN).
//   - A done level that is already high on entry to WAIT does NOT advance the FSM.
//  LEN_ISSUE
//   - len_block = {pld_bytes[63:0], aad_bytes[63:0]}: AAD length in bits [63:0], payload length in [127:64].
//   - Both little-endian byte order. Upper bits are zero-extended or truncated to 64.
//   - len_valid is asserted the cycle after entry.
//   - On len_valid & len_ready -> LEN_WAIT.
//  LEN_WAIT: on lens_done rising edge -> FIN.
//  FIN: seq_done=1 for one cycle, busy<=0 -> IDLE.
//  keep=0 beat: counts 0 bytes but is still issued as an all-zero block. Upstream avoids this except for an empty last beat.
//  Counters wrap modulo 2^LEN_W. No saturation.
//  Valid and done in the same cycle: the handshake is processed first; done is evaluated only in WAIT.
//  rst_n low mid-message: immediate return to IDLE. All valids drop asynchronously; counters clear.
// CONFIGURATION
//  POLY_SEQ_TIMEOUT_EN defined
//   - A counter runs in every X_WAIT state and clears on state change.
//   - Reaching TIMEOUT_CYCLES: timeout_err <= 1 (sticky until reset or next start), FSM -> IDLE, busy <= 0, no seq_done.
//  POLY_SEQ_TIMEOUT_EN undefined
//   - No counter and no timeout_err port. The sequencer waits in X_WAIT indefinitely.
// TESTING
//  - Full blocks: 1 AAD beat (keep=FFFF, last), 1 payload beat (keep=FFFF, last), adapter model.
//    -> aad/pld/len each issued once; len_block = {64'd16, 64'd16}; seq_done pulses once.
//  - Partial block: AAD keep=001F, data=all FF.
//    -> aad_data = {88'h0, 40'hFFFFFFFFFF}; aad_bytes = 5; len_block[63:0] = 5.
//  - Multi-beat payload: 3 beats with keep FFFF, FFFF, 00FF.
//    -> three pld_valid pulses, each issued only after a pld_done rise; pld_bytes = 40.
//  - Backpressure: aad_ready held 0 for 7 cycles.
//    -> aad_data stable and aad_valid high all 7 cycles; s_aad_ready stays 0.
//  - aad_none=1 and pld_none=1 -> only a len block is issued, with value 128'h0; seq_done pulses.
//  - Reset mid-message: rst_n low during PLD_WAIT.
//    -> busy=0, all valids 0, counters 0. A new start then runs normally.
//    -> With POLY_SEQ_TIMEOUT_EN and pld_done never rising: timeout_err=1 after TIMEOUT_CYCLES.

Source files
------------

// File: rtl/poly1305_block_sequencer_if.sv
// rtl/poly1305_block_sequencer_if.sv - stream and adapter handshake bundle for the poly1305 block sequencer
interface poly1305_block_sequencer_if;
  logic         s_aad_valid;
  logic         s_aad_ready;
  logic [127:0] s_aad_data;
  logic [15:0]  s_aad_keep;
  logic         s_aad_last;
  logic         s_pld_valid;
  logic         s_pld_ready;
  logic [127:0] s_pld_data;
  logic [15:0]  s_pld_keep;
  logic         s_pld_last;
  logic         aad_valid;
  logic         aad_ready;
  logic [127:0] aad_data;
  logic [15:0]  aad_keep;
  logic         pld_valid;
  logic         pld_ready;
  logic [127:0] pld_data;
  logic [15:0]  pld_keep;
  logic         len_valid;
  logic         len_ready;
  logic [127:0] len_block;
  logic         aad_done;
  logic         pld_done;
  logic         lens_done;

  modport slave (
    input  s_aad_valid, s_aad_data, s_aad_keep, s_aad_last,
    output s_aad_ready,
    input  s_pld_valid, s_pld_data, s_pld_keep, s_pld_last,
    output s_pld_ready,
    output aad_valid, aad_data, aad_keep,
    input  aad_ready,
    output pld_valid, pld_data, pld_keep,
    input  pld_ready,
    output len_valid, len_block,
    input  len_ready,
    input  aad_done, pld_done, lens_done
  );

  modport master (
    output s_aad_valid, s_aad_data, s_aad_keep, s_aad_last,
    input  s_aad_ready,
    output s_pld_valid, s_pld_data, s_pld_keep, s_pld_last,
    input  s_pld_ready,
    input  aad_valid, aad_data, aad_keep,
    output aad_ready,
    input  pld_valid, pld_data, pld_keep,
    output pld_ready,
    input  len_valid, len_block,
    output len_ready,
    output aad_done, pld_done, lens_done
  );
endinterface

// File: rtl/poly1305_block_sequencer.sv
// rtl/poly1305_block_sequencer.sv - AAD/payload/length block sequencer feeding a ChaCha20-Poly1305 adapter
// Optional watchdog (TIMEOUT_CYCLES, timeout_err) built when POLY_SEQ_TIMEOUT_EN is defined.
module poly1305_block_sequencer #(
  parameter int LEN_W = 64
`ifdef POLY_SEQ_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 1024
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             aad_none,
  input  logic             pld_none,
  poly1305_block_sequencer_if.slave bus,
  output logic             busy,
  output logic             seq_done,
  output logic [LEN_W-1:0] aad_bytes,
  output logic [LEN_W-1:0] pld_bytes
`ifdef POLY_SEQ_TIMEOUT_EN
  , output logic           timeout_err
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_AAD_ISSUE, S_AAD_WAIT, S_PLD_ISSUE,
    S_PLD_WAIT, S_LEN_ISSUE, S_LEN_WAIT, S_FIN
  } state_t;

  state_t state_q, state_d;

  logic         aad_valid_q, pld_valid_q, len_valid_q;
  logic [127:0] aad_data_q, pld_data_q;
  logic [15:0]  aad_keep_q, pld_keep_q;
  logic         last_q, pld_none_q, busy_q;
  logic         aad_done_q, pld_done_q, lens_done_q;

  function automatic logic [127:0] mask_bytes(input logic [127:0] d, input logic [15:0] k);
    logic [127:0] m;
    m = '0;
    for (int i = 0; i < 16; i++)
      if (k[i]) m[8*i +: 8] = d[8*i +: 8];
    return m;
  endfunction

  wire start_acc = (state_q == S_IDLE) && start;
  wire aad_acc   = bus.s_aad_valid && bus.s_aad_ready;
  wire pld_acc   = bus.s_pld_valid && bus.s_pld_ready;
  wire aad_hs    = aad_valid_q && bus.aad_ready;
  wire pld_hs    = pld_valid_q && bus.pld_ready;
  wire len_hs    = len_valid_q && bus.len_ready;
  wire aad_rise  = bus.aad_done && !aad_done_q;
  wire pld_rise  = bus.pld_done && !pld_done_q;
  wire lens_rise = bus.lens_done && !lens_done_q;

  // Only the current WAIT state's done edge counts; edges seen elsewhere are dropped.
  wire in_wait  = (state_q == S_AAD_WAIT) || (state_q == S_PLD_WAIT) || (state_q == S_LEN_WAIT);
  wire cur_rise = ((state_q == S_AAD_WAIT) && aad_rise) ||
                  ((state_q == S_PLD_WAIT) && pld_rise) ||
                  ((state_q == S_LEN_WAIT) && lens_rise);

`ifdef POLY_SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt;
  logic            timeout_q;
  wire wd_fire = in_wait && !cur_rise && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (start) state_d = !aad_none ? S_AAD_ISSUE :
                                        (!pld_none ? S_PLD_ISSUE : S_LEN_ISSUE);
      S_AAD_ISSUE: if (aad_hs) state_d = S_AAD_WAIT;
      S_AAD_WAIT:  if (aad_rise) state_d = !last_q ? S_AAD_ISSUE :
                                           (pld_none_q ? S_LEN_ISSUE : S_PLD_ISSUE);
      S_PLD_ISSUE: if (pld_hs) state_d = S_PLD_WAIT;
      S_PLD_WAIT:  if (pld_rise) state_d = last_q ? S_LEN_ISSUE : S_PLD_ISSUE;
      S_LEN_ISSUE: if (len_hs) state_d = S_LEN_WAIT;
      S_LEN_WAIT:  if (lens_rise) state_d = S_FIN;
      S_FIN:       state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
`ifdef POLY_SEQ_TIMEOUT_EN
    if (wd_fire) state_d = S_IDLE;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aad_valid_q <= 1'b0;
      pld_valid_q <= 1'b0;
      len_valid_q <= 1'b0;
      aad_data_q  <= '0;
      pld_data_q  <= '0;
      aad_keep_q  <= '0;
      pld_keep_q  <= '0;
      aad_bytes   <= '0;
      pld_bytes   <= '0;
      last_q      <= 1'b0;
      pld_none_q  <= 1'b0;
      busy_q      <= 1'b0;
      aad_done_q  <= 1'b0;
      pld_done_q  <= 1'b0;
      lens_done_q <= 1'b0;
    end else begin
      aad_done_q  <= bus.aad_done;
      pld_done_q  <= bus.pld_done;
      lens_done_q <= bus.lens_done;
      if (start_acc) begin
        aad_bytes  <= '0;
        pld_bytes  <= '0;
        pld_none_q <= pld_none;
        busy_q     <= 1'b1;
      end
      if (state_q == S_FIN) busy_q <= 1'b0;
`ifdef POLY_SEQ_TIMEOUT_EN
      if (wd_fire) busy_q <= 1'b0;
`endif
      if (aad_acc) begin
        aad_valid_q <= 1'b1;
        aad_data_q  <= mask_bytes(bus.s_aad_data, bus.s_aad_keep);
        aad_keep_q  <= bus.s_aad_keep;
        aad_bytes   <= aad_bytes + LEN_W'($countones(bus.s_aad_keep));
        last_q      <= bus.s_aad_last;
      end else if (aad_hs) begin
        aad_valid_q <= 1'b0;
      end
      if (pld_acc) begin
        pld_valid_q <= 1'b1;
        pld_data_q  <= mask_bytes(bus.s_pld_data, bus.s_pld_keep);
        pld_keep_q  <= bus.s_pld_keep;
        pld_bytes   <= pld_bytes + LEN_W'($countones(bus.s_pld_keep));
        last_q      <= bus.s_pld_last;
      end else if (pld_hs) begin
        pld_valid_q <= 1'b0;
      end
      // len_valid rises the cycle after LEN_ISSUE entry and drops on its handshake.
      if (state_q == S_LEN_ISSUE) len_valid_q <= !len_hs;
    end
  end

`ifdef POLY_SEQ_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_cnt <= (in_wait && !cur_rise && !wd_fire) ? wd_cnt + 1'b1 : '0;
      if (start_acc)    timeout_q <= 1'b0;
      else if (wd_fire) timeout_q <= 1'b1;
    end
  end
  assign timeout_err = timeout_q;
`endif

  assign bus.s_aad_ready = (state_q == S_AAD_ISSUE) && !aad_valid_q;
  assign bus.s_pld_ready = (state_q == S_PLD_ISSUE) && !pld_valid_q;
  assign bus.aad_valid   = aad_valid_q;
  assign bus.aad_data    = aad_data_q;
  assign bus.aad_keep    = aad_keep_q;
  assign bus.pld_valid   = pld_valid_q;
  assign bus.pld_data    = pld_data_q;
  assign bus.pld_keep    = pld_keep_q;
  assign bus.len_valid   = len_valid_q;
  assign bus.len_block   = {64'(pld_bytes), 64'(aad_bytes)};
  assign busy            = busy_q;
  assign seq_done        = (state_q == S_FIN);

endmodule

// File: tb/tb_poly1305_block_sequencer.sv
// tb/tb_poly1305_block_sequencer.sv - self-checking bench for poly1305_block_sequencer
module tb_poly1305_block_sequencer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        aad_none = 1'b0;
  logic        pld_none = 1'b0;
  logic        busy, seq_done;
  logic [63:0] aad_bytes, pld_bytes;
`ifdef POLY_SEQ_TIMEOUT_EN
  logic        timeout_err;
`endif

  poly1305_block_sequencer_if bus();

  poly1305_block_sequencer #(
    .LEN_W(64)
`ifdef POLY_SEQ_TIMEOUT_EN
    , .TIMEOUT_CYCLES(64)
`endif
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .aad_none(aad_none),
    .pld_none(pld_none),
    .bus(bus),
    .busy(busy),
    .seq_done(seq_done),
    .aad_bytes(aad_bytes),
    .pld_bytes(pld_bytes)
`ifdef POLY_SEQ_TIMEOUT_EN
    , .timeout_err(timeout_err)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic aad_rdy = 1'b1, pld_rdy = 1'b1, len_rdy = 1'b1;
  logic suppress_pld = 1'b0;
  assign bus.aad_ready = aad_rdy;
  assign bus.pld_ready = pld_rdy;
  assign bus.len_ready = len_rdy;

  logic [143:0] exp_aad_q[$];
  logic [143:0] exp_pld_q[$];
  logic [127:0] exp_len_q[$];
  int aad_cnt = 0, pld_cnt = 0, len_cnt = 0, sd_cnt = 0;
  int aad_dly = 0, pld_dly = 0, len_dly = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Adapter model: consumes issued blocks against the scoreboard, raises done 3 cycles later.
  always @(negedge clk) begin
    logic [143:0] e;
    logic [127:0] l;
    if (!rst_n) begin
      aad_dly = 0; pld_dly = 0; len_dly = 0;
      bus.aad_done = 1'b0; bus.pld_done = 1'b0; bus.lens_done = 1'b0;
    end else begin
      bus.aad_done  = (aad_dly == 1); if (aad_dly > 0) aad_dly--;
      bus.pld_done  = (pld_dly == 1); if (pld_dly > 0) pld_dly--;
      bus.lens_done = (len_dly == 1); if (len_dly > 0) len_dly--;
      if (bus.aad_valid && bus.aad_ready) begin
        check("aad_issued_before_done", (aad_dly != 0) || bus.aad_done, 0);
        if (exp_aad_q.size() == 0) check("aad_unexpected_block", 1, 0);
        else begin
          e = exp_aad_q.pop_front();
          check("aad_data", bus.aad_data, e[127:0]);
          check("aad_keep", bus.aad_keep, e[143:128]);
        end
        aad_cnt++; aad_dly = 3;
      end
      if (bus.pld_valid && bus.pld_ready) begin
        check("pld_issued_before_done", (pld_dly != 0) || bus.pld_done, 0);
        if (exp_pld_q.size() == 0) check("pld_unexpected_block", 1, 0);
        else begin
          e = exp_pld_q.pop_front();
          check("pld_data", bus.pld_data, e[127:0]);
          check("pld_keep", bus.pld_keep, e[143:128]);
        end
        pld_cnt++;
        if (!suppress_pld) pld_dly = 3;
      end
      if (bus.len_valid && bus.len_ready) begin
        if (exp_len_q.size() == 0) check("len_unexpected_block", 1, 0);
        else begin
          l = exp_len_q.pop_front();
          check("len_block", bus.len_block, l);
        end
        len_cnt++; len_dly = 3;
      end
      if (seq_done) sd_cnt++;
    end
  end

  task automatic do_start(input bit an, input bit pn);
    @(posedge clk); #1;
    start = 1'b1; aad_none = an; pld_none = pn;
    @(posedge clk); #1;
    start = 1'b0; aad_none = 1'b0; pld_none = 1'b0;
    @(negedge clk);
    check("start_busy", busy, 1);
  endtask

  task automatic send(input bit is_pld, input logic [127:0] d, input logic [15:0] k,
                      input bit last, input logic [127:0] exp_d);
    bit got = 0;
    @(posedge clk); #1;
    if (is_pld) begin
      bus.s_pld_valid = 1'b1; bus.s_pld_data = d; bus.s_pld_keep = k; bus.s_pld_last = last;
      exp_pld_q.push_back({k, exp_d});
    end else begin
      bus.s_aad_valid = 1'b1; bus.s_aad_data = d; bus.s_aad_keep = k; bus.s_aad_last = last;
      exp_aad_q.push_back({k, exp_d});
    end
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (is_pld ? bus.s_pld_ready : bus.s_aad_ready) begin got = 1; break; end
    end
    check(is_pld ? "pld_beat_accepted" : "aad_beat_accepted", got, 1);
    @(posedge clk); #1;
    if (is_pld) bus.s_pld_valid = 1'b0;
    else        bus.s_aad_valid = 1'b0;
  endtask

  task automatic wait_seq(input int budget);
    int base = sd_cnt;
    bit got = 0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (sd_cnt != base) begin got = 1; break; end
    end
    check("seq_done_seen", got, 1);
    repeat (3) @(negedge clk);
    check("seq_done_once", sd_cnt - base, 1);
    check("busy_after_done", busy, 0);
  endtask

  task automatic full_message();
    logic [127:0] d1, d2;
    int a0, p0, l0;
    d1 = {$urandom, $urandom, $urandom, $urandom};
    d2 = {$urandom, $urandom, $urandom, $urandom};
    a0 = aad_cnt; p0 = pld_cnt; l0 = len_cnt;
    exp_len_q.push_back({64'd16, 64'd16});
    do_start(1'b0, 1'b0);
    send(1'b0, d1, 16'hFFFF, 1'b1, d1);
    send(1'b1, d2, 16'hFFFF, 1'b1, d2);
    wait_seq(300);
    check("full_aad_issued", aad_cnt - a0, 1);
    check("full_pld_issued", pld_cnt - p0, 1);
    check("full_len_issued", len_cnt - l0, 1);
    check("full_aad_bytes", aad_bytes, 16);
    check("full_pld_bytes", pld_bytes, 16);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1, "global timeout");
  end

  initial begin
    logic [127:0] d, d3;
    int a0, p0, l0;
    bit got;
    bus.s_aad_valid = 1'b0; bus.s_aad_data = '0; bus.s_aad_keep = '0; bus.s_aad_last = 1'b0;
    bus.s_pld_valid = 1'b0; bus.s_pld_data = '0; bus.s_pld_keep = '0; bus.s_pld_last = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_seq_done", seq_done, 0);
    check("rst_aad_valid", bus.aad_valid, 0);
    check("rst_pld_valid", bus.pld_valid, 0);
    check("rst_len_valid", bus.len_valid, 0);
    check("rst_s_aad_ready", bus.s_aad_ready, 0);
    check("rst_aad_bytes", aad_bytes, 0);
    check("rst_pld_bytes", pld_bytes, 0);
    check("rst_len_block", bus.len_block, 0);

    full_message();

    // Partial AAD block, no payload.
    p0 = pld_cnt;
    exp_len_q.push_back({64'd0, 64'd5});
    do_start(1'b0, 1'b1);
    send(1'b0, {128{1'b1}}, 16'h001F, 1'b1, {88'h0, 40'hFFFFFFFFFF});
    wait_seq(300);
    check("part_aad_bytes", aad_bytes, 5);
    check("part_pld_bytes", pld_bytes, 0);
    check("part_pld_issued", pld_cnt - p0, 0);

    // Three payload beats, plus a stray start mid-message that must be ignored.
    a0 = aad_cnt; p0 = pld_cnt;
    exp_len_q.push_back({64'd40, 64'd0});
    do_start(1'b1, 1'b0);
    d = {$urandom, $urandom, $urandom, $urandom};
    send(1'b1, d, 16'hFFFF, 1'b0, d);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    d = {$urandom, $urandom, $urandom, $urandom};
    send(1'b1, d, 16'hFFFF, 1'b0, d);
    d3 = {$urandom, $urandom, $urandom, $urandom};
    send(1'b1, d3, 16'h00FF, 1'b1, {64'h0, d3[63:0]});
    wait_seq(300);
    check("multi_pld_issued", pld_cnt - p0, 3);
    check("multi_aad_issued", aad_cnt - a0, 0);
    check("multi_pld_bytes", pld_bytes, 40);
    check("multi_aad_bytes", aad_bytes, 0);

    // Adapter backpressure on the AAD block.
    aad_rdy = 1'b0;
    exp_len_q.push_back({64'd0, 64'd16});
    do_start(1'b0, 1'b1);
    d = {$urandom, $urandom, $urandom, $urandom};
    send(1'b0, d, 16'hFFFF, 1'b1, d);
    for (int n = 0; n < 7; n++) begin
      @(negedge clk);
      check("bp_aad_valid", bus.aad_valid, 1);
      check("bp_aad_data", bus.aad_data, d);
      check("bp_s_aad_ready", bus.s_aad_ready, 0);
    end
    @(posedge clk); #1 aad_rdy = 1'b1;
    wait_seq(300);

    // Both phases skipped: only a zero length block.
    a0 = aad_cnt; p0 = pld_cnt; l0 = len_cnt;
    exp_len_q.push_back(128'h0);
    do_start(1'b1, 1'b1);
    wait_seq(300);
    check("none_aad_issued", aad_cnt - a0, 0);
    check("none_pld_issued", pld_cnt - p0, 0);
    check("none_len_issued", len_cnt - l0, 1);

    // Reset while parked in PLD_WAIT.
    suppress_pld = 1'b1;
    p0 = pld_cnt;
    do_start(1'b0, 1'b0);
    d = {$urandom, $urandom, $urandom, $urandom};
    send(1'b0, d, 16'hFFFF, 1'b1, d);
    send(1'b1, d, 16'h0FFF, 1'b1, {32'h0, d[95:0]});
    got = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (pld_cnt != p0) begin got = 1; break; end
    end
    check("rstmid_pld_issued", got, 1);
    repeat (4) @(negedge clk);
    check("rstmid_busy_before", busy, 1);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    check("rstmid_busy", busy, 0);
    check("rstmid_aad_valid", bus.aad_valid, 0);
    check("rstmid_pld_valid", bus.pld_valid, 0);
    check("rstmid_len_valid", bus.len_valid, 0);
    check("rstmid_aad_bytes", aad_bytes, 0);
    check("rstmid_pld_bytes", pld_bytes, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    suppress_pld = 1'b0;
    full_message();

`ifdef POLY_SEQ_TIMEOUT_EN
    // Payload done never rises: watchdog must abort without seq_done.
    suppress_pld = 1'b1;
    l0 = sd_cnt;
    do_start(1'b1, 1'b0);
    d = {$urandom, $urandom, $urandom, $urandom};
    send(1'b1, d, 16'hFFFF, 1'b1, d);
    repeat (80) @(negedge clk);
    check("wd_timeout_err", timeout_err, 1);
    check("wd_busy", busy, 0);
    check("wd_no_seq_done", sd_cnt - l0, 0);
    suppress_pld = 1'b0;
    exp_len_q.push_back(128'h0);
    do_start(1'b1, 1'b1);
    check("wd_err_cleared", timeout_err, 0);
    wait_seq(300);
`endif

    check("aad_queue_drained", exp_aad_q.size(), 0);
    check("pld_queue_drained", exp_pld_q.size(), 0);
    check("len_queue_drained", exp_len_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
